// File: rtl/interval_timer_bank.sv
// Programmable interval duration bank with an integrated countdown timer.
// Durations are snapshotted at start; writes never disturb a running count.
module interval_timer_bank #(
  parameter int NUM_INTERVALS = 4,
  parameter int WIDTH         = 4,
  parameter int SEL_W         = 2,
  parameter logic [NUM_INTERVALS*WIDTH-1:0] DEFAULTS =
    {4'd1, 4'd2, 4'd3, 4'd6}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             prog_sync,
  input  logic [SEL_W-1:0] time_parameter_selector,
  input  logic [WIDTH-1:0] time_value,
  input  logic [SEL_W-1:0] interval,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             sel_err
);

  localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_INTERVALS);

  typedef logic [NUM_INTERVALS-1:0][WIDTH-1:0] dur_t;
  typedef enum logic {IDLE, RUN} state_t;

  dur_t             dur_q, dur_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exp_q, exp_d;
  logic             sel_err_q, sel_err_d;
  state_t           state_q, state_d;

  logic             sel_ok;
  logic             iv_ok;
  logic [WIDTH-1:0] rd;

  assign sel_ok = {1'b0, time_parameter_selector} < NUM_L;
  assign iv_ok  = {1'b0, interval} < NUM_L;

  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_INTERVALS; i++) begin
      if (interval == SEL_W'(i)) rd = dur_q[i];
    end
  end

  always_comb begin
    dur_d = dur_q;
    if (prog_sync && sel_ok) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        if (time_parameter_selector == SEL_W'(i))
          dur_d[i] = time_value;
      end
    end
  end

  always_comb begin
    value_d   = iv_ok ? rd : value_q;
    sel_err_d = (prog_sync && !sel_ok) || !iv_ok;
  end

  // rd comes from dur_q, so a same-cycle write is not seen by start
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && iv_ok) begin
          if (rd == '0) begin
            exp_d = 1'b1;
          end else begin
            rem_d   = rd;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          rem_d   = '0;
          state_d = IDLE;
        end else if (tick && rem_q != '0) begin
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) begin
            state_d = IDLE;
            exp_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dur_q     <= DEFAULTS;
      value_q   <= DEFAULTS[WIDTH-1:0];
      rem_q     <= '0;
      exp_q     <= 1'b0;
      sel_err_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      dur_q     <= dur_d;
      value_q   <= value_d;
      rem_q     <= rem_d;
      exp_q     <= exp_d;
      sel_err_q <= sel_err_d;
      state_q   <= state_d;
    end
  end

  assign value     = value_q;
  assign remaining = rem_q;
  assign busy      = (state_q == RUN);
  assign expired   = exp_q;
  assign sel_err   = sel_err_q;

endmodule
